tag_retire: RTL and testbench

- Consumer end of the column tag path: the tag allocator launches a tag that shifts across the PE columns, and each column later presents its tagged result.
- tag_retire captures one tagged result per column into a slot and checks every column of a round against the round tag.
- It drains results in column order over a valid/ready stream and drives per-column tag_lock back to the allocator so a column only presents a new tag once its slot is free.

---
 rtl/tag_retire.sv | 165 ++++++++++++++++
 tb/tb_tag_retire.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_retire.sv
// Per-column result capture with in-order drain; col_valid to out_valid in 2 cycles, >=2 cycles/result.
// Backpressure: output held in SEND until out_ready; tag_lock tells the allocator which slots may refill.
module tag_retire #(
  parameter int NUM_COL    = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 32,
  localparam int PW        = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [NUM_COL-1:0]                   col_valid,
  input  logic [NUM_COL-1:0][DATA_WIDTH-1:0]   col_tag,
  input  logic [NUM_COL-1:0][ACC_WIDTH-1:0]    col_data,
  output logic [NUM_COL-1:0]                   tag_lock,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH-1:0]                out_tag,
  output logic [ACC_WIDTH-1:0]                 out_data,
  output logic [PW-1:0]                        out_col,
  output logic                                 round_done,
  output logic                                 err_mismatch,
  output logic                                 err_overflow
);

  typedef enum logic {S_WAIT, S_SEND} state_t;

  state_t                               r_state, w_state_nxt;
  logic [NUM_COL-1:0]                   r_full;
  logic [NUM_COL-1:0][DATA_WIDTH-1:0]   r_tag;
  logic [NUM_COL-1:0][ACC_WIDTH-1:0]    r_data;
  logic [PW-1:0]                        r_ptr;
  logic [DATA_WIDTH-1:0]                r_round_tag;
  logic                                 r_round_tag_vld;
  logic [DATA_WIDTH-1:0]                r_out_tag;
  logic [ACC_WIDTH-1:0]                 r_out_data;
  logic [PW-1:0]                        r_out_col;
  logic                                 r_round_done;
  logic                                 r_err_mismatch;
  logic                                 r_err_overflow;

  logic                                 w_load;
  logic                                 w_accept;
  logic                                 w_last;
  logic                                 w_ovf;
  logic [NUM_COL-1:0]                   w_acc_col;
  logic [NUM_COL-1:0]                   w_cap;

  assign w_last = (r_ptr == PW'(NUM_COL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_WAIT;
    else     r_state <= w_state_nxt;
  end

  // Flush overrides an accept in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (!flush && r_full[r_ptr]) begin
          w_state_nxt = S_SEND;
          w_load      = 1'b1;
        end
      end
      S_SEND: begin
        if (flush) begin
          w_state_nxt = S_WAIT;
        end else if (out_ready) begin
          w_state_nxt = S_WAIT;
          w_accept    = 1'b1;
        end
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  // A slot being drained this cycle may be refilled in the same cycle.
  always_comb begin
    w_acc_col = '0;
    w_cap     = '0;
    for (int i = 0; i < NUM_COL; i++) begin
      w_acc_col[i] = w_accept && (r_ptr == PW'(i));
      w_cap[i]     = col_valid[i] && !flush && (!r_full[i] || w_acc_col[i]);
    end
    w_ovf = !flush && (|(col_valid & r_full & ~w_acc_col));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= '0;
      r_tag  <= '0;
      r_data <= '0;
    end else if (flush) begin
      r_full <= '0;
    end else begin
      for (int i = 0; i < NUM_COL; i++) begin
        if (w_cap[i]) begin
          r_full[i] <= 1'b1;
          r_tag[i]  <= col_tag[i];
          r_data[i] <= col_data[i];
        end else if (w_acc_col[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_tag  <= '0;
      r_out_data <= '0;
      r_out_col  <= '0;
    end else if (w_load) begin
      r_out_tag  <= r_tag[r_ptr];
      r_out_data <= r_data[r_ptr];
      r_out_col  <= r_ptr;
    end
  end

  // The round tag is taken from column 0 as it drains; later columns compare against it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr           <= '0;
      r_round_tag     <= '0;
      r_round_tag_vld <= 1'b0;
      r_round_done    <= 1'b0;
      r_err_mismatch  <= 1'b0;
      r_err_overflow  <= 1'b0;
    end else begin
      r_round_done <= 1'b0;
      if (w_ovf) r_err_overflow <= 1'b1;
      if (flush) begin
        r_ptr           <= '0;
        r_round_tag_vld <= 1'b0;
      end else if (w_accept) begin
        if (r_ptr == '0) begin
          r_round_tag     <= r_out_tag;
          r_round_tag_vld <= 1'b1;
        end else if (r_round_tag_vld && (r_out_tag != r_round_tag)) begin
          r_err_mismatch <= 1'b1;
        end
        if (w_last) begin
          r_ptr           <= '0;
          r_round_done    <= 1'b1;
          r_round_tag_vld <= 1'b0;
        end else begin
          r_ptr <= r_ptr + 1'b1;
        end
      end
    end
  end

  assign tag_lock     = ~r_full;
  assign out_valid    = (r_state == S_SEND);
  assign out_tag      = r_out_tag;
  assign out_data     = r_out_data;
  assign out_col      = r_out_col;
  assign round_done   = r_round_done;
  assign err_mismatch = r_err_mismatch;
  assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_tag_retire.sv
// Bench for tag_retire: slot-level reference model checked every cycle plus directed scenarios.
module tb_tag_retire;
  localparam int NC = 8;
  localparam int DW = 32;
  localparam int AW = 32;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   flush = 1'b0;
  logic [NC-1:0]          col_valid = '0;
  logic [NC-1:0][DW-1:0]  col_tag = '0;
  logic [NC-1:0][AW-1:0]  col_data = '0;
  logic [NC-1:0]          tag_lock;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [DW-1:0]          out_tag;
  logic [AW-1:0]          out_data;
  logic [2:0]             out_col;
  logic                   round_done;
  logic                   err_mismatch;
  logic                   err_overflow;

  tag_retire #(.NUM_COL(NC), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .col_valid(col_valid), .col_tag(col_tag), .col_data(col_data),
    .tag_lock(tag_lock), .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_data(out_data), .out_col(out_col),
    .round_done(round_done), .err_mismatch(err_mismatch), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int          col;
    logic [31:0] tag;
    logic [31:0] data;
  } ent_t;
  ent_t acc_q[$];
  int   done_cnt = 0;

  // Reference model: slot contents, drain pointer, idle/presenting, sticky errors.
  logic [NC-1:0] m_full;
  logic [31:0]   m_tag  [NC];
  logic [31:0]   m_data [NC];
  int            m_ptr;
  logic          m_ov, m_done, m_emm, m_eovf, m_rvld;
  logic [31:0]   m_rtag;

  always @(negedge clk) begin
    logic [NC-1:0] exp_lock;
    logic          acc, ov_n;
    if (rst) begin
      chk("rst_tag_lock", tag_lock, 64'hFF);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_col", out_col, 0);
      chk("rst_round_done", round_done, 0);
      chk("rst_err_mismatch", err_mismatch, 0);
      chk("rst_err_overflow", err_overflow, 0);
      m_full = '0; m_ptr = 0; m_ov = 0; m_done = 0; m_emm = 0; m_eovf = 0;
      m_rvld = 0; m_rtag = '0;
      for (int i = 0; i < NC; i++) begin m_tag[i] = '0; m_data[i] = '0; end
    end else begin
      exp_lock = ~m_full;
      chk("tag_lock", tag_lock, exp_lock);
      chk("out_valid", out_valid, m_ov);
      chk("round_done", round_done, m_done);
      chk("err_mismatch", err_mismatch, m_emm);
      chk("err_overflow", err_overflow, m_eovf);
      if (m_ov) begin
        chk("out_col", out_col, m_ptr);
        chk("out_tag", out_tag, m_tag[m_ptr]);
        chk("out_data", out_data, m_data[m_ptr]);
      end
      if (round_done) done_cnt++;
      if (out_valid && out_ready && !flush)
        acc_q.push_back('{col: int'(out_col), tag: out_tag, data: out_data});

      m_done = 0;
      if (flush) begin
        m_full = '0; m_ptr = 0; m_rvld = 0; ov_n = 0;
      end else begin
        acc = m_ov && out_ready;
        if (acc) begin
          if (m_ptr == 0) begin m_rtag = m_tag[0]; m_rvld = 1; end
          else if (m_rvld && m_tag[m_ptr] != m_rtag) m_emm = 1;
          m_full[m_ptr] = 1'b0;
          if (m_ptr == NC - 1) begin m_ptr = 0; m_done = 1; m_rvld = 0; end
          else m_ptr = m_ptr + 1;
          ov_n = 0;
        end else if (m_ov) begin
          ov_n = 1;
        end else begin
          ov_n = m_full[m_ptr];
        end
        for (int i = 0; i < NC; i++) begin
          if (col_valid[i]) begin
            if (!m_full[i]) begin
              m_full[i] = 1'b1; m_tag[i] = col_tag[i]; m_data[i] = col_data[i];
            end else begin
              m_eovf = 1;
            end
          end
        end
      end
      m_ov = ov_n;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
    col_valid = '0;
  endtask

  task automatic put(input int c, input logic [31:0] t, input logic [31:0] d);
    col_valid[c] = 1'b1;
    col_tag[c]   = t;
    col_data[c]  = d;
  endtask

  task automatic rst_seq();
    rst = 1'b1; cyc(); cyc();
    rst = 1'b0; cyc();
    acc_q.delete(); done_cnt = 0;
  endtask

  task automatic do_flush();
    cyc(); flush = 1'b1; cyc(); flush = 1'b0;
  endtask

  task automatic wait_acc(input int n);
    int k = 0;
    while (acc_q.size() < n && k < 300) begin cyc(); k++; end
    chk("wait_acc_timeout", acc_q.size() >= n, 1);
  endtask

  task automatic wait_ov();
    int k = 0;
    while (!out_valid && k < 40) begin cyc(); k++; end
    chk("wait_ov_timeout", out_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // In-order round, consecutive columns
    rst_seq();
    out_ready = 1'b1;
    for (int i = 0; i < NC; i++) begin cyc(); put(i, 32'h5A, i * 3); end
    cyc();
    wait_acc(8);
    for (int i = 0; i < NC; i++) begin
      chk("t1_col", acc_q[i].col, i);
      chk("t1_tag", acc_q[i].tag, 32'h5A);
      chk("t1_data", acc_q[i].data, i * 3);
    end
    cyc(); cyc();
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_err_mm", err_mismatch, 0);
    chk("t1_err_ovf", err_overflow, 0);

    // Out-of-order fill: column 3 first, drain waits on slot 0
    acc_q.delete();
    cyc(); put(3, 32'h5A, 32'h33);
    repeat (5) cyc();
    chk("t2_wait_ov", out_valid, 0);
    chk("t2_lock3", tag_lock, 64'hF7);
    put(0, 32'h5A, 32'h30);
    cyc();
    chk("t2_lat1_ov", out_valid, 0);
    chk("t2_lat1_lock", tag_lock, 64'hF6);
    put(1, 32'h5A, 32'h31);
    cyc();
    chk("t2_lat2_ov", out_valid, 1);
    chk("t2_lat2_col", out_col, 0);
    chk("t2_lat2_data", out_data, 32'h30);
    put(2, 32'h5A, 32'h32);
    cyc();
    wait_acc(4);
    for (int i = 0; i < 4; i++) chk("t2_order", acc_q[i].col, i);
    chk("t2_data3", acc_q[3].data, 32'h33);
    do_flush();

    // Backpressure hold and overflow on the presenting slot
    acc_q.delete();
    out_ready = 1'b0;
    cyc(); put(0, 32'h5A, 32'hA1);
    cyc(); cyc();
    chk("t3_send", out_valid, 1);
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (k == 3) put(0, 32'h5A, 32'hB2);
    end
    cyc();
    chk("t3_hold_ov", out_valid, 1);
    chk("t3_hold_data", out_data, 32'hA1);
    chk("t3_ovf", err_overflow, 1);
    out_ready = 1'b1;
    wait_acc(1);
    chk("t3_first_data", acc_q[0].data, 32'hA1);

    // Tag mismatch on column 5, sticky through flush
    rst_seq();
    out_ready = 1'b1;
    for (int i = 0; i < NC; i++) begin cyc(); put(i, (i == 5) ? 32'h5B : 32'h5A, i); end
    cyc();
    wait_acc(5);
    chk("t4_mm_before", err_mismatch, 0);
    wait_acc(8);
    cyc();
    chk("t4_mm_after", err_mismatch, 1);
    do_flush();
    cyc();
    chk("t4_mm_flush", err_mismatch, 1);
    rst_seq();
    chk("t4_mm_rst", err_mismatch, 0);

    // Flush with partial round and simultaneous accept
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin cyc(); put(i, 32'h22, 32'h50 + i); end
    cyc(); cyc(); cyc();
    chk("t5_send", out_valid, 1);
    flush = 1'b1; out_ready = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t5_lock", tag_lock, 64'hFF);
    chk("t5_ov", out_valid, 0);
    chk("t5_no_acc", acc_q.size(), 0);
    for (int i = 0; i < NC; i++) begin cyc(); put(i, 32'h11, 32'h100 + i); end
    cyc();
    wait_acc(8);
    for (int i = 0; i < NC; i++) begin
      chk("t5_col", acc_q[i].col, i);
      chk("t5_data", acc_q[i].data, 32'h100 + i);
    end

    // Same-cycle accept and refill of slot 2
    acc_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < NC; i++) begin cyc(); put(i, 32'h44, 32'h60 + i); end
    for (int k = 0; k < 2; k++) begin
      wait_ov();
      out_ready = 1'b1; cyc(); out_ready = 1'b0;
    end
    wait_ov();
    chk("t6_at_col2", out_col, 2);
    out_ready = 1'b1;
    put(2, 32'h44, 32'h77);
    cyc();
    wait_acc(8);
    for (int i = 0; i < NC; i++) if (i != 2) begin cyc(); put(i, 32'h44, 32'h70 + i); end
    cyc();
    wait_acc(16);
    chk("t6_col", acc_q[10].col, 2);
    chk("t6_data", acc_q[10].data, 32'h77);
    chk("t6_first_col2", acc_q[2].data, 32'h62);
    chk("t6_ovf", err_overflow, 0);
    chk("t6_mm", err_mismatch, 0);

    // Asynchronous reset while presenting
    out_ready = 1'b0;
    cyc(); put(0, 32'h9, 32'h9);
    cyc(); cyc();
    chk("t7_send", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("t7_async_ov", out_valid, 0);
    chk("t7_async_lock", tag_lock, 64'hFF);
    cyc();
    rst = 1'b0;
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
